// File: rtl/tw_rom_loader_pkg.sv
// Shared constants for the twiddle ROM map and the loader FSM.
// The twiddle generator imports the same base constants from here, so the
// ROM layout has a single definition.

`ifndef OVERALL_BITS
`define OVERALL_BITS 64
`endif

package tw_rom_loader_pkg;

    // ROM layout: NTT tables start at NTT_TW_BASE. Each table holds two
    // moduli, one in each half of the word. The FFT table sits at FFT_TW_BASE.
    localparam int FFT_TW_BASE         = 896;
    localparam int NTT_TW_BASE         = 256;
    localparam int ENTRIES_PER_MODULUS = 71;

    // Loader FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Write-enable patterns: full word, low half, high half
    localparam logic [1:0] WE_FULL = 2'b11;
    localparam logic [1:0] WE_LO   = 2'b01;
    localparam logic [1:0] WE_HI   = 2'b10;

endpackage : tw_rom_loader_pkg

// File: rtl/tw_rom_loader.sv
// Twiddle ROM loader: accepts one table of twiddles on a valid/ready stream
// and writes it into the twiddle ROM. The FFT table takes the full word. Each
// NTT modulus writes one half of the word, chosen by the parity of its index.
// Each accepted beat is written one cycle later through a registered write
// stage. A running XOR of the beats is published as a checksum when the
// load completes.

module tw_rom_loader
    import tw_rom_loader_pkg::*;
#(
    parameter int ADDR_WIDTH_ROM = 10,
    parameter int LOGQ_MAX       = 54,
    parameter int ROM_DATA_W     = 2*`OVERALL_BITS,
    parameter int NUM_MODULI     = 18,
    parameter int ENTRIES        = ENTRIES_PER_MODULUS
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           is_fft,
    input  logic [$clog2(NUM_MODULI)-1:0]  constants_sel,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [ROM_DATA_W-1:0]          in_data,
    output logic [1:0]                     rom_we,
    output logic [ADDR_WIDTH_ROM-1:0]      rom_waddr,
    output logic [ROM_DATA_W-1:0]          rom_wdata,
    output logic                           busy,
    output logic                           done,
    output logic                           err,
    output logic [ROM_DATA_W-1:0]          checksum
);

    localparam int CNT_W = $clog2(ENTRIES);

    // FSM and load context
    state_e                      state_q,    state_d;
    logic [CNT_W-1:0]            cnt_q,      cnt_d;
    logic [ADDR_WIDTH_ROM-1:0]   base_q,     base_d;
    logic [1:0]                  mask_q,     mask_d;
    logic [ROM_DATA_W-1:0]       xor_q,      xor_d;
    logic [ROM_DATA_W-1:0]       checksum_q, checksum_d;
    logic                        err_q,      err_d;

    // Write stage: holds the beat accepted in the previous cycle
    logic [1:0]                  we_q,       we_d;
    logic [ADDR_WIDTH_ROM-1:0]   waddr_q,    waddr_d;
    logic [ROM_DATA_W-1:0]       wdata_q,    wdata_d;

    // Beat formatting helpers
    logic [ROM_DATA_W-1:0]       payload;
    logic [ROM_DATA_W-1:0]       beat_word;
    logic [ROM_DATA_W-1:0]       beat_sum;
    logic                        sel_legal;

    // Format the incoming beat for the ROM word and for the running XOR
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default
        // first, so no path can leave it unassigned and infer a latch.
        payload   = ROM_DATA_W'(in_data[LOGQ_MAX-1:0]);
        beat_word = '0;
        beat_sum  = payload;
        sel_legal = int'(constants_sel) < NUM_MODULI;
        unique case (mask_q)
            WE_FULL: begin
                beat_word = in_data;
                beat_sum  = in_data;
            end
            WE_HI:   beat_word = payload << LOGQ_MAX;
            default: beat_word = payload;
        endcase
    end

    // Next-state logic: start decode, beat acceptance, write stage and checksum
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        base_d     = base_q;
        mask_d     = mask_q;
        xor_d      = xor_q;
        checksum_d = checksum_q;
        err_d      = 1'b0;
        we_d       = 2'b00;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (is_fft) begin
                        state_d = ST_LOAD;
                        base_d  = ADDR_WIDTH_ROM'(FFT_TW_BASE);
                        mask_d  = WE_FULL;
                        cnt_d   = '0;
                        xor_d   = '0;
                    end else if (sel_legal) begin
                        state_d = ST_LOAD;
                        base_d  = ADDR_WIDTH_ROM'(NTT_TW_BASE +
                                  (int'(constants_sel) >> 1) * ENTRIES);
                        mask_d  = constants_sel[0] ? WE_HI : WE_LO;
                        cnt_d   = '0;
                        xor_d   = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            ST_LOAD: begin
                if (in_valid) begin
                    we_d    = mask_q;
                    waddr_d = base_q + ADDR_WIDTH_ROM'(cnt_q);
                    wdata_d = beat_word;
                    xor_d   = xor_q ^ beat_sum;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(ENTRIES - 1)) begin
                        // Publish the checksum with done; the final write
                        // drains from the write stage during DONE.
                        state_d    = ST_DONE;
                        checksum_d = xor_q ^ beat_sum;
                        cnt_d      = '0;
                    end
                end
            end

            ST_DONE: state_d = ST_IDLE;

            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so that every
        // flop samples the pre-edge value of every other flop.
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            base_q     <= '0;
            mask_q     <= WE_FULL;
            xor_q      <= '0;
            checksum_q <= '0;
            err_q      <= 1'b0;
            we_q       <= 2'b00;
            waddr_q    <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            base_q     <= base_d;
            mask_q     <= mask_d;
            xor_q      <= xor_d;
            checksum_q <= checksum_d;
            err_q      <= err_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
        end
    end

    // Strobes are masked by rst so that a write pending when reset arrives
    // never reaches the ROM, even in the reset cycle itself.
    assign in_ready  = (state_q == ST_LOAD) && !rst;
    assign busy      = (state_q != ST_IDLE) && !rst;
    assign done      = (state_q == ST_DONE) && !rst;
    assign err       = err_q && !rst;
    assign rom_we    = rst ? 2'b00 : we_q;
    assign rom_waddr = waddr_q;
    assign rom_wdata = wdata_q;
    assign checksum  = checksum_q;

endmodule : tw_rom_loader

// File: tb/tb_tw_rom_loader.sv
// Scoreboard bench for tw_rom_loader. The driver issues loads and pushes the
// expected ROM writes, checksums and err pulses into queues. An independent
// monitor pops and compares them whenever the DUT presents them.

module tb_tw_rom_loader;

    localparam int AW = 10;
    localparam int LQ = 54;
    localparam int DW = 128;
    localparam int NM = 18;
    localparam int EN = 71;
    localparam int SW = $clog2(NM);

    typedef struct {
        logic [AW-1:0] addr;
        logic [1:0]    we;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          is_fft = 1'b0;
    logic [SW-1:0] constants_sel = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [1:0]    rom_we;
    logic [AW-1:0] rom_waddr;
    logic [DW-1:0] rom_wdata;
    logic          busy;
    logic          done;
    logic          err;
    logic [DW-1:0] checksum;

    int total = 0;
    int bad   = 0;

    wr_t           exp_wr[$];
    logic [DW-1:0] exp_cs[$];
    int            err_pending = 0;
    logic [DW-1:0] last_cs = '0;
    int            n_writes = 0;

    tw_rom_loader #(
        .ADDR_WIDTH_ROM (AW),
        .LOGQ_MAX       (LQ),
        .ROM_DATA_W     (DW),
        .NUM_MODULI     (NM),
        .ENTRIES        (EN)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .is_fft        (is_fft),
        .constants_sel (constants_sel),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .rom_we        (rom_we),
        .rom_waddr     (rom_waddr),
        .rom_wdata     (rom_wdata),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .checksum      (checksum)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: expected ROM write for beat i of a table
    function automatic wr_t model_write(input bit fft, input int sel, input int i, input logic [DW-1:0] d);
        wr_t w;
        int  base;
        base   = fft ? 896 : 256 + (sel / 2) * EN;
        w.addr = AW'(base + i);
        w.data = '0;
        if (fft) begin
            w.we   = 2'b11;
            w.data = d;
        end else if (sel % 2 == 0) begin
            w.we = 2'b01;
            w.data[LQ-1:0] = d[LQ-1:0];
        end else begin
            w.we = 2'b10;
            w.data[2*LQ-1 -: LQ] = d[LQ-1:0];
        end
        return w;
    endfunction

    // Reference model: contribution of one beat to the checksum
    function automatic logic [DW-1:0] model_sum(input bit fft, input logic [DW-1:0] d);
        logic [DW-1:0] s;
        s = '0;
        if (fft) s = d;
        else     s[LQ-1:0] = d[LQ-1:0];
        return s;
    endfunction

    function automatic logic [DW-1:0] rand_word();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Monitor: compares every DUT write, done and err against the queues
    always @(negedge clk) begin
        bit wrote;
        wrote = 1'b0;
        if (rst) begin
            check("we_in_reset", DW'(rom_we), '0);
        end else begin
            if (rom_we != 2'b00) begin
                wr_t e;
                wrote = 1'b1;
                n_writes++;
                if (exp_wr.size() == 0) begin
                    check("unexpected_write_addr", DW'(rom_waddr), '1);
                end else begin
                    e = exp_wr.pop_front();
                    check("wr_addr", DW'(rom_waddr), DW'(e.addr));
                    check("wr_we",   DW'(rom_we),    DW'(e.we));
                    check("wr_data", rom_wdata,      e.data);
                end
            end
            if (done) begin
                check("done_with_final_write", DW'(wrote), DW'(1));
                if (exp_cs.size() == 0) check("unexpected_done", DW'(done), '0);
                else                    check("checksum", checksum, exp_cs.pop_front());
            end
            if (err) begin
                if (err_pending == 0) check("unexpected_err", DW'(err), '0);
                else begin
                    err_pending--;
                    check("err_busy", DW'(busy), '0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until it is accepted
    task automatic send_beat(input logic [DW-1:0] d);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk);
            ok = in_ready;
            tick();
        end
        if (!ok) check("beat_accept_timeout", '0, '1);
        in_valid = 1'b0;
    endtask

    // Issue a legal load. gap: 0 none, 1 alternate idle cycles, 2 random.
    // abort > 0: assert rst right after beat number 'abort' is accepted.
    // poke: pulse start mid-load and during DONE; both must be ignored.
    task automatic run_load(input bit fft, input int sel, input bit ramp,
                            input int gap, input int abort, input bit poke);
        logic [DW-1:0] d [EN];
        logic [DW-1:0] cs;
        int            n;
        cs = '0;
        n  = (abort > 0) ? abort : EN;
        for (int i = 0; i < EN; i++) begin
            d[i] = ramp ? DW'(i) : rand_word();
            cs   = cs ^ model_sum(fft, d[i]);
        end
        // The beat accepted just before reset is dropped from the write stage
        for (int i = 0; i < ((abort > 0) ? abort - 1 : EN); i++)
            exp_wr.push_back(model_write(fft, sel, i, d[i]));
        if (abort == 0) exp_cs.push_back(cs);

        check("checksum_held", checksum, last_cs);
        start = 1'b1;
        is_fft = fft;
        constants_sel = SW'(sel);
        tick();
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i > 0 && (gap == 1 || (gap == 2 && $urandom_range(0, 3) == 0))) begin
                int g;
                g = (gap == 1) ? 1 : $urandom_range(1, 3);
                repeat (g) tick();
            end
            if (poke && i == 10) begin
                start = 1'b1;
                is_fft = 1'b0;
                constants_sel = SW'(25);
            end
            send_beat(d[i]);
            start = 1'b0;
        end

        if (abort > 0) begin
            rst = 1'b1;
            @(negedge clk);
            check("abort_we", DW'(rom_we), '0);
            check("abort_done", DW'(done), '0);
            tick();
            tick();
            rst = 1'b0;
            last_cs = '0;
            @(negedge clk);
            check("abort_busy", DW'(busy), '0);
            check("abort_checksum", checksum, '0);
            tick();
        end else begin
            if (poke) begin
                start = 1'b1;
                is_fft = 1'b1;
            end
            @(negedge clk);
            check("ready_low_in_done", DW'(in_ready), '0);
            tick();
            start = 1'b0;
            @(negedge clk);
            check("idle_after_done", DW'(busy), '0);
            last_cs = cs;
            tick();
        end
    endtask

    task automatic illegal_start(input int sel);
        err_pending++;
        start = 1'b1;
        is_fft = 1'b0;
        constants_sel = SW'(sel);
        tick();
        start = 1'b0;
        tick();
        @(negedge clk);
        check("illegal_busy", DW'(busy), '0);
        check("illegal_err_seen", DW'(err_pending), '0);
        tick();
    endtask

    initial begin
        int writes_before;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready",    DW'(in_ready),  '0);
        check("rst_busy",     DW'(busy),      '0);
        check("rst_done",     DW'(done),      '0);
        check("rst_err",      DW'(err),       '0);
        check("rst_waddr",    DW'(rom_waddr), '0);
        check("rst_wdata",    rom_wdata,      '0);
        check("rst_checksum", checksum,       '0);
        tick();
        rst = 1'b0;
        tick();

        run_load(1'b1, 0, 1'b1, 0, 0, 1'b0);   // FFT ramp, back to back
        run_load(1'b0, 5, 1'b0, 0, 0, 1'b0);   // NTT odd modulus
        writes_before = n_writes;
        run_load(1'b0, 0, 1'b0, 1, 0, 1'b0);   // NTT even, alternating gaps
        check("gap_write_count", DW'(n_writes - writes_before), DW'(EN));
        illegal_start(18);
        run_load(1'b0, 3, 1'b0, 0, 30, 1'b0);  // abort after 30 beats
        run_load(1'b1, 0, 1'b1, 0, 0, 1'b0);   // FFT after abort
        writes_before = n_writes;
        run_load(1'b1, 0, 1'b0, 0, 0, 1'b1);   // ignored starts
        check("poke_write_count", DW'(n_writes - writes_before), DW'(EN));

        for (int k = 0; k < 5; k++) begin
            int sel;
            bit fft;
            fft = ($urandom_range(0, 2) == 0);
            sel = $urandom_range(0, 31);
            if (!fft && sel >= NM) illegal_start(sel);
            else run_load(fft, sel, 1'b0, 2, 0, 1'b0);
        end

        repeat (5) tick();
        check("writes_left",   DW'(exp_wr.size()), '0);
        check("checksums_left", DW'(exp_cs.size()), '0);
        check("errs_left",     DW'(err_pending),   '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_tw_rom_loader
